multicycle_mem_responder: RTL

//  Memory-side end of the multi-cycle CPU's request interface: serves the level-held
//  mem_read / mem_write requests the control FSM drives for LATENCY consecutive states.

---
 rtl/multicycle_mem_responder_pkg.sv | 41 ++++
 rtl/multicycle_mem_responder_mem_word_array.sv | 26 ++
 rtl/multicycle_mem_responder.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/multicycle_mem_responder_pkg.sv
// Shared types for the multi-cycle memory responder: FSM state encodings,
// request opcodes, error causes and the access classification helper.
package multicycle_mem_responder_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Request opcode as {mem_write, mem_read}.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } mem_op_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BOTH_OPS   = 2'd1,
    ERR_MISALIGNED = 2'd2,
    ERR_RANGE      = 2'd3
  } err_cause_e;

  // Hold counter width; large enough for the biggest legal LATENCY.
  localparam int CNT_W = 4;

  // Decide why (if at all) a completed access must be rejected.
  function automatic err_cause_e classify_access(input mem_op_e    op,
                                                 input logic [1:0] byte_off,
                                                 input logic       in_range);
    err_cause_e cause;
    cause = ERR_NONE;
    if (op == OP_BOTH)        cause = ERR_BOTH_OPS;
    else if (byte_off != 2'b00) cause = ERR_MISALIGNED;
    else if (!in_range)       cause = ERR_RANGE;
    return cause;
  endfunction

endpackage

// File: rtl/multicycle_mem_responder_mem_word_array.sv
// Word-addressed storage: synchronous write, asynchronous read.
module mem_word_array #(
  parameter int DEPTH      = 16384,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = $clog2(DEPTH),
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Commit a write on the clock edge when enabled.
  // NOTE: storage has no reset so it maps onto RAM macros; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/multicycle_mem_responder.sv
// Memory-side responder for the multi-cycle CPU: counts how long a level-held
// read/write request stays stable, commits it once after LATENCY cycles and
// pulses ready (with err on a rejected access).
module multicycle_mem_responder
  import multicycle_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384,
  parameter int LATENCY    = 4,
  parameter     INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  ready,
  output logic                  err,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LATENCY - 1);

  if (LATENCY < 2 || LATENCY > 15) begin : g_bad_latency
    $error("multicycle_mem_responder: LATENCY must be in 2..15");
  end

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  mem_op_e               op_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] dout_q;

  logic                  req;
  mem_op_e               op;
  logic                  match;
  logic                  capture;
  logic                  fire;
  logic                  in_range;
  err_cause_e            cause;
  logic                  access_ok;
  logic                  wr_en;
  logic                  read_ok;
  logic [DATA_WIDTH-1:0] rd_data;

  assign req   = mem_read | mem_write;
  assign op    = mem_op_e'({mem_write, mem_read});
  assign match = req && (op == op_q) && (addr == addr_q);

  assign in_range  = addr_q[ADDR_WIDTH-1:2] < (ADDR_WIDTH-2)'(DEPTH);
  assign cause     = classify_access(op_q, addr_q[1:0], in_range);
  assign access_ok = (cause == ERR_NONE);

  // A synchronous reset in the completing cycle cancels the access entirely.
  assign ready   = fire && !reset;
  assign err     = ready && !access_ok;
  assign wr_en   = ready && access_ok && (op_q == OP_WRITE);
  assign read_ok = ready && access_ok && (op_q == OP_READ);
  assign busy    = (state_q == MEM_BUSY);

  assign dout = read_ok ? rd_data : (err ? '0 : dout_q);

  // Next-state, hold counter and capture decisions.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      MEM_IDLE: begin
        if (req) begin
          state_d = MEM_BUSY;
          cnt_d   = CNT_W'(1);
          capture = 1'b1;
        end
      end
      MEM_BUSY: begin
        if (!match) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          fire    = 1'b1;
          state_d = MEM_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MEM_DONE: begin
        if (!req) begin
          state_d = MEM_IDLE;
          cnt_d   = '0;
        end else if (!match) begin
          state_d = MEM_BUSY;
          cnt_d   = CNT_W'(1);
          capture = 1'b1;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, captured request and held read data.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= OP_NONE;
      din_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q <= addr;
        op_q   <= op;
        din_q  <= din;
      end
      if (read_ok) dout_q <= rd_data;
    end
  end

  mem_word_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W),
    .INIT_FILE  (INIT_FILE)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .widx  (addr_q[IDX_W+1:2]),
    .wdata (din_q),
    .ridx  (addr_q[IDX_W+1:2]),
    .rdata (rd_data)
  );

endmodule
